serial_word_deserializer: RTL and testbench
===========================================

# serial_word_deserializer

Serial-in, parallel-out deserializer sitting directly downstream of the single-bit D flip-flop register stage. It samples the registered serial bit stream (the flip-flop's Q) one bit per qualified clock, assembles WIDTH-bit words, and presents each word on a valid/ready output port with a one-entry holding buffer and overflow reporting.

## Interface

Parameters:
- WIDTH, 8, bits per assembled word (≥2).

Ports:
- clk  input  1  rising-edge clock, shared with the upstream flip-flop stage.
- rst_n  input  1  asynchronous, active-low reset.
- bit_in  input  1  serial data bit; driven by the upstream flip-flop Q.
- bit_valid  input  1  bit_in is sampled on this edge.
- frame_start  input  1  marks bit_in as bit 0 of a new word; discards any partial word.
- data_out  output  WIDTH  assembled word; bit 0 is the first bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out on this edge when data_valid=1.
- overflow  output  1  one-cycle pulse: a completed word was dropped.
- parity_err  output  1  present only with SWD_PARITY_EN (see Configuration).

## Operation

- States: IDLE (no bits since reset/frame boundary), SHIFT (1..WIDTH-1 bits collected), and PARITY when SWD_PARITY_EN is defined.
- IDLE --bit_valid--> SHIFT, storing bit 0, count=1.
- SHIFT: each bit_valid stores bit at index count, count++. At count=WIDTH-1 with bit_valid the word completes; return to IDLE (or enter PARITY).
- frame_start with bit_valid: bit_in becomes bit 0, count=1, partial word discarded, in any state. frame_start without bit_valid: go to IDLE, count=0.
- Word completion: if data_valid=0, or data_valid=1 and data_ready=1 on the same edge, load data_out and set data_valid=1. If data_valid=1 and data_ready=0, drop the new word, keep data_out unchanged, and pulse overflow.
- data_ready with data_valid=1 and no completion: data_valid clears.
- data_ready with data_valid=0 is ignored.
- Bit counter width is $clog2(WIDTH). It never exceeds WIDTH-1; wrap to 0 at completion.

## Timing

- Reset (async assert, sync release on the next clk): state=IDLE, count=0, data_out=0, data_valid=0, overflow=0, parity_err=0. A partial word is lost.
- Latency: the last bit is sampled at edge N; data_valid=1 and data_out are valid after edge N (visible in cycle N+1).
- Back-to-back: sustained one bit per cycle gives one word every WIDTH cycles (WIDTH+1 with parity). No bubbles are required.
- Simultaneous completion and data_ready: the old word is consumed and the new word is loaded on the same edge. data_valid stays 1.
- The overflow pulse lasts exactly one cycle per dropped word.

## Configuration

- SWD_PARITY_EN defined: after WIDTH data bits, one extra bit_valid bit is taken as even parity. The word is delivered regardless. parity_err is registered alongside data_out, updates only when a word is loaded, and is 1 when the XOR of the data bits and the parity bit is 1. frame_start during PARITY discards the word.
- SWD_PARITY_EN undefined: there is no PARITY state and no parity_err port. A word completes on the WIDTH-th bit.

## Structure

- Package swd_pkg: state enum (SWD_IDLE, SWD_SHIFT, SWD_PARITY) and the counter-width function/constant.
- One sub-module, swd_shift_core: WIDTH-bit shift register plus bit counter with load/clear. The top level holds the FSM, output buffer, overflow and parity logic.

## Test plan

- Reset mid-word: after 3 bits, pulse rst_n low. Required: outputs return to 0 immediately. Then send frame_start+8 bits of 0xA5 (LSB first). Required: data_out=0xA5 and data_valid=1 one cycle after the 8th bit.
- Back-to-back: stream 0x3C then 0xC3 continuously with data_ready=1. Required: both words delivered 8 cycles apart, no overflow.
- Backpressure: data_ready=0, send 0x11 then 0x22. Required: data_out stays 0x11, overflow pulses once at the completion of 0x22. Raising data_ready then clears data_valid.
- Simultaneous: data_valid=1 (0x55), and data_ready=1 on the edge 0xAA completes. Required: data_out=0xAA, data_valid stays 1, overflow=0.
- Resync: send 5 bits, then frame_start+8 bits of 0x0F. Required: data_out=0x0F, and the partial 5 bits are never emitted.
- Gapped input: bit_valid toggling every other cycle for 0x81. Required: data_out=0x81 after the 8th qualified bit. With SWD_PARITY_EN, a parity bit of 0 gives parity_err=0, and a parity bit of 1 gives parity_err=1.

Source files
------------

// File: rtl/swd_pkg.sv
// Shared types for the serial word deserializer: FSM state encoding and counter sizing.
// Combinational only; no backpressure.
package swd_pkg;

    typedef enum logic [1:0] {
        SWD_IDLE   = 2'd0,
        SWD_SHIFT  = 2'd1,
        SWD_PARITY = 2'd2
    } swd_state_e;

    // Bit counter width; WIDTH=2 still needs one bit.
    function automatic int swd_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/swd_if.sv
// Serial-in / word-out bus of the deserializer; slave = deserializer, master = bit source plus word sink.
// No logic, zero latency; data_ready is the word-side backpressure.
interface swd_if #(parameter int WIDTH = 8);

    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overflow;
`ifdef SWD_PARITY_EN
    logic             parity_err;

    modport slave  (input  bit_in, bit_valid, frame_start, data_ready,
                    output data_out, data_valid, overflow, parity_err);
    modport master (output bit_in, bit_valid, frame_start, data_ready,
                    input  data_out, data_valid, overflow, parity_err);
`else
    modport slave  (input  bit_in, bit_valid, frame_start, data_ready,
                    output data_out, data_valid, overflow);
    modport master (output bit_in, bit_valid, frame_start, data_ready,
                    input  data_out, data_valid, overflow);
`endif

endinterface

// File: rtl/swd_shift_core.sv
// Indexed shift register plus bit counter; word_next is the word including the bit on this edge (0-cycle view).
// No backpressure: writes whenever restart/advance is asserted.
module swd_shift_core
    import swd_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = swd_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             clear,
    input  logic             restart,
    input  logic             advance,
`ifdef SWD_PARITY_EN
    output logic [WIDTH-1:0] word,
`endif
    output logic [WIDTH-1:0] word_next,
    output logic             wrap
);

    logic [CW-1:0]    count;
    logic [CW-1:0]    wr_idx;
    logic [WIDTH-1:0] shreg;

    // A restart writes bit 0 regardless of how far the discarded word got.
    assign wr_idx = restart ? '0 : count;
    assign wrap   = (wr_idx == CW'(WIDTH - 1));
`ifdef SWD_PARITY_EN
    assign word   = shreg;
`endif

    always_comb begin
        word_next         = shreg;
        word_next[wr_idx] = bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (restart || advance) begin
            shreg <= word_next;
            count <= wrap ? '0 : wr_idx + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-word deserializer with one-entry output buffer; word visible the cycle after its last bit. Optional even parity via SWD_PARITY_EN.
// Backpressure: a word completing while the buffer is full and data_ready=0 is dropped with a one-cycle overflow pulse.
module serial_word_deserializer
    import swd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    swd_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = SWD_IDLE;
    localparam logic [1:0] ST_SHIFT  = SWD_SHIFT;
`ifdef SWD_PARITY_EN
    localparam logic [1:0] ST_PARITY = SWD_PARITY;
`endif

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             clear;
    logic             restart;
    logic             advance;
    logic             wrap;
    logic             complete;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] cmp_word;
`ifdef SWD_PARITY_EN
    logic [WIDTH-1:0] word;
    logic             cmp_perr;
`endif

    swd_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bus.bit_in),
        .clear     (clear),
        .restart   (restart),
        .advance   (advance),
`ifdef SWD_PARITY_EN
        .word      (word),
`endif
        .word_next (word_next),
        .wrap      (wrap)
    );

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        restart   = 1'b0;
        advance   = 1'b0;
        complete  = 1'b0;
        cmp_word  = word_next;
`ifdef SWD_PARITY_EN
        cmp_perr  = 1'b0;
`endif
        // frame_start overrides everything, including a pending parity bit.
        if (bus.frame_start) begin
            if (bus.bit_valid) begin
                restart   = 1'b1;
                state_nxt = ST_SHIFT;
            end else begin
                clear     = 1'b1;
                state_nxt = ST_IDLE;
            end
        end else if (bus.bit_valid) begin
            case (state)
`ifdef SWD_PARITY_EN
                ST_PARITY: begin
                    complete  = 1'b1;
                    cmp_word  = word;
                    cmp_perr  = (^word) ^ bus.bit_in;
                    state_nxt = ST_IDLE;
                end
`endif
                default: begin
                    advance = 1'b1;
                    if (wrap) begin
`ifdef SWD_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
`endif
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.overflow   <= 1'b0;
`ifdef SWD_PARITY_EN
            bus.parity_err <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            bus.overflow <= 1'b0;
            if (complete) begin
                // A consume on the same edge frees the buffer for the new word.
                if (!bus.data_valid || bus.data_ready) begin
                    bus.data_out   <= cmp_word;
                    bus.data_valid <= 1'b1;
`ifdef SWD_PARITY_EN
                    bus.parity_err <= cmp_perr;
`endif
                end else begin
                    bus.overflow <= 1'b1;
                end
            end else if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer; works with or without SWD_PARITY_EN.
module tb_serial_word_deserializer;

    localparam int W = 8;
`ifdef SWD_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    swd_if #(.WIDTH(W)) bus ();

    serial_word_deserializer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bus.bit_in      = b;
        bus.bit_valid   = 1'b1;
        bus.frame_start = fs;
        tick();
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    // Data bits LSB first, then the even-parity bit when parity is built in.
    task automatic send_word(input logic [W-1:0] w, input logic fs);
        for (int i = 0; i < W; i++) send_bit(w[i], fs && (i == 0));
`ifdef SWD_PARITY_EN
        send_bit(^w, 1'b0);
`endif
    endtask

    task automatic drain();
        bus.data_ready = 1'b1;
        tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.data_valid); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", bus.data_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
`ifdef SWD_PARITY_EN
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b expected 0", bus.parity_err); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_word();
        send_word(8'hFF, 1'b1);
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b expected 1", bus.data_valid); end
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid: got %b expected 0", bus.data_valid); end
        total++; if (bus.data_out !== 8'h00) begin bad++; $display("FAIL async_reset_data: got %h expected 00", bus.data_out); end
        tick();
        rst_n = 1'b1;
        tick();
        send_word(8'hA5, 1'b1);
        total++; if (bus.data_out !== 8'hA5) begin bad++; $display("FAIL after_reset_data: got %h expected a5", bus.data_out); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL after_reset_valid: got %b expected 1", bus.data_valid); end
        drain();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL after_reset_drain: got %b expected 0", bus.data_valid); end
    endtask

    task automatic test_back_to_back();
        logic        q[$];
        logic [W-1:0] w0 = 8'h3C;
        logic [W-1:0] w1 = 8'hC3;
        for (int i = 0; i < W; i++) q.push_back(w0[i]);
`ifdef SWD_PARITY_EN
        q.push_back(^w0);
`endif
        for (int i = 0; i < W; i++) q.push_back(w1[i]);
`ifdef SWD_PARITY_EN
        q.push_back(^w1);
`endif
        bus.data_ready = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            send_bit(q[i], i == 0);
            total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow bit %0d: got %b expected 0", i, bus.overflow); end
            if (i == L - 1) begin
                total++; if (bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin bad++; $display("FAIL b2b_word0: got %h/%b expected 3c/1", bus.data_out, bus.data_valid); end
            end
            if (i == L) begin
                total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL b2b_consume0: got %b expected 0", bus.data_valid); end
            end
            if (i == 2 * L - 1) begin
                total++; if (bus.data_out !== 8'hC3 || bus.data_valid !== 1'b1) begin bad++; $display("FAIL b2b_word1: got %h/%b expected c3/1", bus.data_out, bus.data_valid); end
            end
        end
        tick();
        bus.data_ready = 1'b0;
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL b2b_final_drain: got %b expected 0", bus.data_valid); end
    endtask

    task automatic test_backpressure();
        bus.data_ready = 1'b0;
        send_word(8'h11, 1'b1);
        total++; if (bus.data_out !== 8'h11 || bus.data_valid !== 1'b1) begin bad++; $display("FAIL bp_first: got %h/%b expected 11/1", bus.data_out, bus.data_valid); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL bp_first_ovf: got %b expected 0", bus.overflow); end
        send_word(8'h22, 1'b0);
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf_pulse: got %b expected 1", bus.overflow); end
        total++; if (bus.data_out !== 8'h11) begin bad++; $display("FAIL bp_hold: got %h expected 11", bus.data_out); end
        tick();
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL bp_ovf_one_cycle: got %b expected 0", bus.overflow); end
        total++; if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h11) begin bad++; $display("FAIL bp_still_held: got %h/%b expected 11/1", bus.data_out, bus.data_valid); end
        drain();
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b expected 0", bus.data_valid); end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] w = 8'hAA;
        bus.data_ready = 1'b0;
        send_word(8'h55, 1'b1);
        total++; if (bus.data_out !== 8'h55 || bus.data_valid !== 1'b1) begin bad++; $display("FAIL sim_first: got %h/%b expected 55/1", bus.data_out, bus.data_valid); end
        for (int i = 0; i < L; i++) begin
            bus.data_ready = (i == L - 1);
            send_bit((i < W) ? w[i] : ^w, i == 0);
        end
        total++; if (bus.data_out !== 8'hAA) begin bad++; $display("FAIL sim_data: got %h expected aa", bus.data_out); end
        total++; if (bus.data_valid !== 1'b1) begin bad++; $display("FAIL sim_valid: got %b expected 1", bus.data_valid); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sim_ovf: got %b expected 0", bus.overflow); end
        tick();
        bus.data_ready = 1'b0;
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL sim_drain: got %b expected 0", bus.data_valid); end
    endtask

    task automatic test_resync();
        logic [4:0]   part = 5'b01101;
        logic [W-1:0] w    = 8'h0F;
        bus.data_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(part[i], i == 0);
        total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL resync_partial: got %b expected 0", bus.data_valid); end
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], i == 0);
            if (i == 2) begin
                total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL resync_no_stale: got %b expected 0", bus.data_valid); end
            end
        end
`ifdef SWD_PARITY_EN
        send_bit(^w, 1'b0);
`endif
        total++; if (bus.data_out !== 8'h0F || bus.data_valid !== 1'b1) begin bad++; $display("FAIL resync_word: got %h/%b expected 0f/1", bus.data_out, bus.data_valid); end
        drain();
        // Bare frame_start (no bit) must also discard a partial word.
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        send_word(8'h3C, 1'b0);
        total++; if (bus.data_out !== 8'h3C || bus.data_valid !== 1'b1) begin bad++; $display("FAIL resync_bare_fs: got %h/%b expected 3c/1", bus.data_out, bus.data_valid); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL resync_bare_ovf: got %b expected 0", bus.overflow); end
        drain();
    endtask

    task automatic test_gapped();
        logic [W-1:0] w = 8'h81;
        bus.data_ready = 1'b0;
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], i == 0);
            if (i == W - 2) begin
                total++; if (bus.data_valid !== 1'b0) begin bad++; $display("FAIL gap_early: got %b expected 0", bus.data_valid); end
            end
            if (i != W - 1) tick();
        end
`ifdef SWD_PARITY_EN
        tick();
        send_bit(1'b0, 1'b0);
        total++; if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL gap_perr_good: got %b expected 0", bus.parity_err); end
`endif
        total++; if (bus.data_out !== 8'h81 || bus.data_valid !== 1'b1) begin bad++; $display("FAIL gap_word: got %h/%b expected 81/1", bus.data_out, bus.data_valid); end
`ifdef SWD_PARITY_EN
        drain();
        for (int i = 0; i < W; i++) begin
            send_bit(w[i], i == 0);
            tick();
        end
        send_bit(1'b1, 1'b0);
        total++; if (bus.parity_err !== 1'b1) begin bad++; $display("FAIL gap_perr_bad: got %b expected 1", bus.parity_err); end
        total++; if (bus.data_out !== 8'h81 || bus.data_valid !== 1'b1) begin bad++; $display("FAIL gap_word_bad_par: got %h/%b expected 81/1", bus.data_out, bus.data_valid); end
`endif
        drain();
    endtask

    initial begin
        bus.bit_in      = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.data_ready  = 1'b0;
        tick();
        tick();
        test_reset();
        test_reset_mid_word();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_resync();
        test_gapped();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
